pdp11_operand_store: RTL and testbench

- Destination write-back unit for the PDP-11 datapath; the store-side counterpart of operand fetch.
- Takes an ALU result plus the destination addressing mode and register, resolves the effective address through all eight PDP-11 modes, and performs the required register side effects.
- Writes the result to the register file or to data memory over a req/ack bus.
- Sits between execute and the register file / data memory port.

---
 rtl/pdp11_pkg.sv | 57 +++++
 rtl/pdp11_ea_calc.sv | 60 ++++++
 rtl/pdp11_operand_store.sv | 209 ++++++++++++++++++++
 tb/tb_pdp11_operand_store.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp11_pkg.sv
// ============================================================================
//  Module      : pdp11_pkg
//  Description : Shared types and constants for the PDP-11 operand store path
//                (addressing modes, store FSM states, register indices).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pdp11_pkg;

  // Machine word and byte widths used throughout the store path
  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  // Special-purpose general registers
  localparam logic [2:0] SP_IDX = 3'd6;
  localparam logic [2:0] PC_IDX = 3'd7;

  // The eight PDP-11 destination addressing modes
  typedef enum logic [2:0] {
    REG         = 3'd0,
    REG_DEF     = 3'd1,
    AUTOINC     = 3'd2,
    AUTOINC_DEF = 3'd3,
    AUTODEC     = 3'd4,
    AUTODEC_DEF = 3'd5,
    INDEX       = 3'd6,
    INDEX_DEF   = 3'd7
  } addr_mode_t;

  // Store sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    IDX_RD = 3'd2,
    PTR_RD = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } store_state_t;

  // Auto-increment/decrement step. SP and PC always step by a word so they
  // stay word aligned; deferred modes step over a word pointer.
  function automatic logic [WORD_W-1:0] inc_size(input addr_mode_t mode,
                                                 input logic [2:0] reg_sel,
                                                 input logic       byte_op);
    logic [WORD_W-1:0] inc;
    inc = 16'd2;
    if (byte_op && (reg_sel != SP_IDX) && (reg_sel != PC_IDX) &&
        (mode != AUTOINC_DEF) && (mode != AUTODEC_DEF)) begin
      inc = 16'd1;
    end
    return inc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pdp11_ea_calc.sv
// ============================================================================
//  Module      : pdp11_ea_calc
//  Description : Combinational effective-address / pointer calculator. Given
//                the addressing mode, the base register value and the index
//                word, produces the register side-effect value and the
//                address (EA or pointer) used by the next bus phase.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pdp11_ea_calc
  import pdp11_pkg::*;
(
  input  addr_mode_t        mode,
  input  logic [2:0]        reg_sel,
  input  logic              byte_op,
  input  logic [WORD_W-1:0] rn,
  input  logic [WORD_W-1:0] idx,
  output logic              upd_en,
  output logic [WORD_W-1:0] upd_val,
  output logic [WORD_W-1:0] addr
);

  logic [WORD_W-1:0] w_inc;
  logic [WORD_W-1:0] w_rn_up;
  logic [WORD_W-1:0] w_rn_dn;

  assign w_inc   = inc_size(mode, reg_sel, byte_op);
  assign w_rn_up = rn + w_inc;
  assign w_rn_dn = rn - w_inc;

  // Per-mode register update and address selection; index modes add the
  // fetched displacement to the supplied base.
  always_comb begin
    upd_en  = 1'b0;
    upd_val = rn;
    addr    = rn;
    case (mode)
      REG, REG_DEF: begin
        addr = rn;
      end
      AUTOINC, AUTOINC_DEF: begin
        upd_en  = 1'b1;
        upd_val = w_rn_up;
        addr    = rn;
      end
      AUTODEC, AUTODEC_DEF: begin
        upd_en  = 1'b1;
        upd_val = w_rn_dn;
        addr    = w_rn_dn;
      end
      default: begin
        addr = rn + idx;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pdp11_operand_store.sv
// ============================================================================
//  Module      : pdp11_operand_store
//  Description : PDP-11 destination write-back unit. Resolves the destination
//                effective address for all eight modes, applies register
//                side effects and writes the result to a register or to data
//                memory over a req/ack bus.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pdp11_operand_store
  import pdp11_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic [2:0]        reg_sel,
  input  logic              byte_op,
  input  logic [DATA_W-1:0] result,
  output logic [2:0]        reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              reg_wr_en,
  output logic [2:0]        reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              odd_err
);

  store_state_t r_state;
  store_state_t w_next;

  addr_mode_t        r_mode;
  logic [2:0]        r_reg;
  logic              r_byte;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_rn;     // base register captured in CALC for index modes
  logic [ADDR_W-1:0] r_addr;   // EA or pointer, depending on the phase

  logic [DATA_W-1:0] w_pc_next;
  logic [DATA_W-1:0] w_idx_base;
  logic [DATA_W-1:0] w_calc_rn;
  logic              w_upd_en;
  logic [DATA_W-1:0] w_upd_val;
  logic [ADDR_W-1:0] w_ea;

  // In IDX_RD the read port is looking at PC, so a PC-relative base is the
  // incremented PC while any other base comes from the CALC-cycle capture.
  assign w_pc_next  = reg_rd_data + 16'd2;
  assign w_idx_base = (r_reg == PC_IDX) ? w_pc_next : r_rn;
  assign w_calc_rn  = (r_state == IDX_RD) ? w_idx_base : reg_rd_data;

  pdp11_ea_calc u_ea_calc (
    .mode    (r_mode),
    .reg_sel (r_reg),
    .byte_op (r_byte),
    .rn      (w_calc_rn),
    .idx     (mem_rdata),
    .upd_en  (w_upd_en),
    .upd_val (w_upd_val),
    .addr    (w_ea)
  );

  // State register plus operand/address latches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_mode   <= REG;
      r_reg    <= 3'd0;
      r_byte   <= 1'b0;
      r_result <= '0;
      r_rn     <= '0;
      r_addr   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode   <= addr_mode_t'(mode);
            r_reg    <= reg_sel;
            r_byte   <= byte_op;
            r_result <= result;
          end
        end
        CALC: begin
          r_rn   <= reg_rd_data;
          r_addr <= w_ea;
        end
        IDX_RD: begin
          if (mem_ack) begin
            r_addr <= w_ea;
          end
        end
        PTR_RD: begin
          if (mem_req && mem_ack) begin
            r_addr <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state decode and all bus/register-port outputs
  always_comb begin
    w_next      = r_state;
    reg_rd_addr = 3'd0;
    reg_wr_en   = 1'b0;
    reg_wr_addr = 3'd0;
    reg_wr_data = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_byte    = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    busy        = 1'b0;
    done        = 1'b0;
    odd_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = CALC;
        end
      end
      CALC: begin
        busy        = 1'b1;
        reg_rd_addr = r_reg;
        if (r_mode == REG) begin
          reg_wr_en   = 1'b1;
          reg_wr_addr = r_reg;
          reg_wr_data = r_byte ? {reg_rd_data[15:8], r_result[7:0]} : r_result;
        end else if (w_upd_en) begin
          reg_wr_en   = 1'b1;
          reg_wr_addr = r_reg;
          reg_wr_data = w_upd_val;
        end
        case (r_mode)
          REG:                        w_next = DONE;
          REG_DEF, AUTOINC, AUTODEC:  w_next = WRITE;
          AUTOINC_DEF, AUTODEC_DEF:   w_next = PTR_RD;
          default:                    w_next = IDX_RD;
        endcase
      end
      IDX_RD: begin
        busy        = 1'b1;
        reg_rd_addr = PC_IDX;
        mem_req     = 1'b1;
        mem_addr    = reg_rd_data;
        if (mem_ack) begin
          reg_wr_en   = 1'b1;
          reg_wr_addr = PC_IDX;
          reg_wr_data = w_pc_next;
          w_next      = (r_mode == INDEX_DEF) ? PTR_RD : WRITE;
        end
      end
      PTR_RD: begin
        busy = 1'b1;
        if (r_addr[0]) begin
          odd_err = 1'b1;
          w_next  = IDLE;
        end else begin
          mem_req  = 1'b1;
          mem_addr = r_addr;
          if (mem_ack) begin
            w_next = WRITE;
          end
        end
      end
      WRITE: begin
        busy = 1'b1;
        if (!r_byte && r_addr[0]) begin
          odd_err = 1'b1;
          w_next  = IDLE;
        end else begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_byte  = r_byte;
          mem_addr  = r_addr;
          mem_wdata = r_byte ? {r_result[7:0], r_result[7:0]} : r_result;
          if (mem_ack) begin
            w_next = DONE;
          end
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_pdp11_operand_store.sv
// ============================================================================
//  Module      : tb_pdp11_operand_store
//  Description : Self-checking bench for pdp11_operand_store: directed vector
//                table, reset-abort sequence and randomized stores against a
//                behavioural model of the PDP-11 destination modes.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pdp11_operand_store;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  mode;
  logic [2:0]  reg_sel;
  logic        byte_op;
  logic [15:0] result;
  logic [2:0]  reg_rd_addr;
  logic [15:0] reg_rd_data;
  logic        reg_wr_en;
  logic [2:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        mem_req;
  logic        mem_we;
  logic        mem_byte;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ack   = 1'b0;
  logic        busy;
  logic        done;
  logic        odd_err;

  always #5 clk = ~clk;

  pdp11_operand_store #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .reg_sel(reg_sel),
    .byte_op(byte_op), .result(result), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_byte(mem_byte), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done),
    .odd_err(odd_err)
  );

  // Environment: register file and word-organised little-endian memory
  logic [15:0] regs [8];
  logic [15:0] mem  [32768];
  logic [15:0] ld_val [8];
  logic        ld_regs  = 1'b0;
  logic        ld_mem   = 1'b0;
  logic        fill_req = 1'b0;
  logic [15:0] ld_maddr = 16'h0;
  logic [15:0] ld_mdata = 16'h0;
  int          lat = 0;
  int          txn_cnt = 0;
  int          wr_cnt  = 0;
  logic [15:0] last_waddr = 16'h0;
  logic [15:0] last_wdata = 16'h0;
  logic        last_wbyte = 1'b0;
  int          wcnt = 0;

  assign reg_rd_data = regs[reg_rd_addr];

  always @(posedge clk) begin
    if (ld_regs) begin
      for (int i = 0; i < 8; i++) regs[i] <= ld_val[i];
    end else if (reg_wr_en) begin
      regs[reg_wr_addr] <= reg_wr_data;
    end
    if (fill_req) begin
      for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    end
    if (ld_mem) mem[ld_maddr[15:1]] = ld_mdata;
    if (mem_req && mem_ack) begin
      txn_cnt = txn_cnt + 1;
      if (mem_we) begin
        wr_cnt     = wr_cnt + 1;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
        last_wbyte = mem_byte;
        if (!mem_byte)        mem[mem_addr[15:1]]       = mem_wdata;
        else if (mem_addr[0]) mem[mem_addr[15:1]][15:8] = mem_wdata[15:8];
        else                  mem[mem_addr[15:1]][7:0]  = mem_wdata[7:0];
      end
    end
  end

  // Memory responder: ack after 'lat' wait cycles of a held request
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    if (!mem_req) begin
      wcnt = 0;
    end else if (wcnt >= lat) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr[15:1]];
    end else begin
      wcnt = wcnt + 1;
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [15:0] rdw(input logic [15:0] a);
    return mem[a[15:1]];
  endfunction

  // Reference model: outcome of one store computed from the mode rules
  logic [15:0] m_regs [8];
  bit          m_wr, m_err, m_byte;
  logic [15:0] m_addr, m_data;

  task automatic model(input logic [2:0] m, input logic [2:0] rs, input logic b,
                       input logic [15:0] res);
    logic [15:0] inc, ea, p, x;
    bit deref;
    for (int i = 0; i < 8; i++) m_regs[i] = regs[i];
    m_wr = 0; m_err = 0; m_byte = b; m_addr = 0; m_data = 0;
    ea = 0; p = 0; x = 0; deref = 0;
    inc = (b && rs < 3'd6 && m != 3'd3 && m != 3'd5) ? 16'd1 : 16'd2;
    case (m)
      3'd0: m_regs[rs] = b ? {m_regs[rs][15:8], res[7:0]} : res;
      3'd1: ea = m_regs[rs];
      3'd2: begin ea = m_regs[rs]; m_regs[rs] = m_regs[rs] + inc; end
      3'd3: begin p = m_regs[rs]; m_regs[rs] = m_regs[rs] + 16'd2; deref = 1; end
      3'd4: begin m_regs[rs] = m_regs[rs] - inc; ea = m_regs[rs]; end
      3'd5: begin m_regs[rs] = m_regs[rs] - 16'd2; p = m_regs[rs]; deref = 1; end
      default: begin
        x = rdw(m_regs[7]);
        m_regs[7] = m_regs[7] + 16'd2;
        ea = m_regs[rs] + x;
        if (m == 3'd7) begin p = ea; deref = 1; end
      end
    endcase
    if (m != 3'd0) begin
      if (deref) begin
        if (p[0]) m_err = 1;
        else ea = rdw(p);
      end
      if (!m_err) begin
        if (!b && ea[0]) m_err = 1;
        else begin
          m_wr = 1; m_addr = ea; m_data = b ? {res[7:0], res[7:0]} : res;
        end
      end
    end
  endtask

  task automatic pulse_ld_regs();
    @(negedge clk); ld_regs = 1'b1;
    @(negedge clk); ld_regs = 1'b0;
  endtask

  task automatic put_mem(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk); ld_maddr = a; ld_mdata = d; ld_mem = 1'b1;
    @(negedge clk); ld_mem = 1'b0;
  endtask

  // Issue one store; k = sample index (1 = cycle after start) of done/odd_err
  int k;
  bit got_done, got_err, busy1;

  task automatic run_store(input logic [2:0] m, input logic [2:0] rs, input logic b,
                           input logic [15:0] res);
    @(negedge clk);
    mode = m; reg_sel = rs; byte_op = b; result = res; start = 1'b1;
    k = 0; got_done = 0; got_err = 0; busy1 = 0;
    while (k < 400 && !got_done && !got_err) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (k == 1) busy1 = busy;
      if (done) got_done = 1;
      if (odd_err) got_err = 1;
    end
    if (!got_done && !got_err) begin
      checks++;
      $display("FAIL timeout: neither done nor odd_err within %0d cycles", k);
    end
  endtask

  typedef struct packed {
    logic [2:0]  m;
    logic [2:0]  rs;
    logic        b;
    logic [15:0] res;
    logic [15:0] rn;
    logic [15:0] pc;
    logic [15:0] ma0, md0, ma1, md1;
    logic [3:0]  lat;
    logic [15:0] e_rn, e_pc;
    logic [3:0]  e_txn;
    logic        e_wr;
    logic [15:0] e_addr, e_data;
    logic        e_byte, e_err;
    logic [4:0]  e_k;
  } vec_t;

  vec_t vt [14];
  int   w0, t0;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 3'd0; reg_sel = 3'd0; byte_op = 1'b0; result = 16'h0;
    for (int i = 0; i < 8; i++) ld_val[i] = 16'h0;
    //            m    rs   b     res       rn        pc        ma0       md0       ma1       md1       lat   e_rn      e_pc      txn   wr    addr      data      byte  err   k
    vt[0]  = '{3'd0,3'd3,1'b1,16'hABCD,16'h1234,16'h0000,16'hFFF0,16'h0000,16'hFFF0,16'h0000,4'd0,16'h12CD,16'h0000,4'd0,1'b0,16'h0000,16'h0000,1'b0,1'b0,5'd2};
    vt[1]  = '{3'd2,3'd1,1'b0,16'h5555,16'h0100,16'h0000,16'hFFF0,16'h0000,16'hFFF0,16'h0000,4'd0,16'h0102,16'h0000,4'd1,1'b1,16'h0100,16'h5555,1'b0,1'b0,5'd3};
    vt[2]  = '{3'd2,3'd1,1'b1,16'h5555,16'h0100,16'h0000,16'hFFF0,16'h0000,16'hFFF0,16'h0000,4'd0,16'h0101,16'h0000,4'd1,1'b1,16'h0100,16'h5555,1'b1,1'b0,5'd3};
    vt[3]  = '{3'd4,3'd6,1'b1,16'h00A7,16'h1000,16'h0000,16'hFFF0,16'h0000,16'hFFF0,16'h0000,4'd0,16'h0FFE,16'h0000,4'd1,1'b1,16'h0FFE,16'hA7A7,1'b1,1'b0,5'd3};
    vt[4]  = '{3'd7,3'd7,1'b0,16'h2468,16'h0200,16'h0200,16'h0200,16'h0010,16'h0212,16'h0300,4'd3,16'h0202,16'h0202,4'd3,1'b1,16'h0300,16'h2468,1'b0,1'b0,5'd14};
    vt[5]  = '{3'd1,3'd2,1'b0,16'h1111,16'h0101,16'h0000,16'hFFF0,16'h0000,16'hFFF0,16'h0000,4'd0,16'h0101,16'h0000,4'd0,1'b0,16'h0000,16'h0000,1'b0,1'b1,5'd2};
    vt[6]  = '{3'd3,3'd4,1'b0,16'h2222,16'h0301,16'h0000,16'hFFF0,16'h0000,16'hFFF0,16'h0000,4'd0,16'h0303,16'h0000,4'd0,1'b0,16'h0000,16'h0000,1'b0,1'b1,5'd2};
    vt[7]  = '{3'd5,3'd5,1'b0,16'h1357,16'h0402,16'h0000,16'h0400,16'h0600,16'hFFF0,16'h0000,4'd0,16'h0400,16'h0000,4'd2,1'b1,16'h0600,16'h1357,1'b0,1'b0,5'd4};
    vt[8]  = '{3'd6,3'd0,1'b0,16'h9999,16'h0100,16'h0200,16'h0200,16'h0020,16'hFFF0,16'h0000,4'd0,16'h0100,16'h0202,4'd2,1'b1,16'h0120,16'h9999,1'b0,1'b0,5'd4};
    vt[9]  = '{3'd0,3'd5,1'b0,16'hBEEF,16'h0000,16'h0000,16'hFFF0,16'h0000,16'hFFF0,16'h0000,4'd0,16'hBEEF,16'h0000,4'd0,1'b0,16'h0000,16'h0000,1'b0,1'b0,5'd2};
    vt[10] = '{3'd3,3'd1,1'b1,16'h00C3,16'h0500,16'h0000,16'h0500,16'h0700,16'hFFF0,16'h0000,4'd0,16'h0502,16'h0000,4'd2,1'b1,16'h0700,16'hC3C3,1'b1,1'b0,5'd4};
    vt[11] = '{3'd7,3'd0,1'b0,16'h7777,16'h0010,16'h0200,16'h0200,16'h0004,16'h0014,16'h0800,4'd0,16'h0010,16'h0202,4'd3,1'b1,16'h0800,16'h7777,1'b0,1'b0,5'd5};
    vt[12] = '{3'd6,3'd7,1'b1,16'h0042,16'h0300,16'h0300,16'h0300,16'h0011,16'hFFF0,16'h0000,4'd0,16'h0302,16'h0302,4'd2,1'b1,16'h0313,16'h4242,1'b1,1'b0,5'd4};
    vt[13] = '{3'd4,3'd2,1'b1,16'h0055,16'h0200,16'h0000,16'hFFF0,16'h0000,16'hFFF0,16'h0000,4'd0,16'h01FF,16'h0000,4'd1,1'b1,16'h01FF,16'h5555,1'b1,1'b0,5'd3};

    // Reset with memory fill and cleared registers
    fill_req = 1'b1;
    pulse_ld_regs();
    fill_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {3'd0, busy, done, odd_err, mem_req, mem_we, mem_byte, reg_wr_en,
                      reg_rd_addr, reg_wr_addr, mem_addr}, 32'h0);
    chk("reset_data", {mem_wdata, reg_wr_data}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int v = 0; v < 14; v++) begin
      for (int i = 0; i < 8; i++) ld_val[i] = 16'h0;
      ld_val[vt[v].rs] = vt[v].rn;
      ld_val[7]        = vt[v].pc;
      pulse_ld_regs();
      put_mem(vt[v].ma0, vt[v].md0);
      put_mem(vt[v].ma1, vt[v].md1);
      lat = int'(vt[v].lat);
      t0 = txn_cnt; w0 = wr_cnt;
      run_store(vt[v].m, vt[v].rs, vt[v].b, vt[v].res);
      chk($sformatf("v%0d_rn", v), {16'h0, regs[vt[v].rs]}, {16'h0, vt[v].e_rn});
      chk($sformatf("v%0d_pc", v), {16'h0, regs[7]}, {16'h0, vt[v].e_pc});
      chk($sformatf("v%0d_txn", v), txn_cnt - t0, {28'h0, vt[v].e_txn});
      chk($sformatf("v%0d_wrcnt", v), wr_cnt - w0, {31'h0, vt[v].e_wr});
      if (vt[v].e_wr) begin
        chk($sformatf("v%0d_waddr", v), {16'h0, last_waddr}, {16'h0, vt[v].e_addr});
        chk($sformatf("v%0d_wdata", v), {16'h0, last_wdata}, {16'h0, vt[v].e_data});
        chk($sformatf("v%0d_wbyte", v), {31'h0, last_wbyte}, {31'h0, vt[v].e_byte});
      end
      chk($sformatf("v%0d_err", v), {31'h0, got_err}, {31'h0, vt[v].e_err});
      chk($sformatf("v%0d_done", v), {31'h0, got_done}, {31'h0, ~vt[v].e_err});
      chk($sformatf("v%0d_lat", v), k, {27'h0, vt[v].e_k});
      chk($sformatf("v%0d_busy1", v), {31'h0, busy1}, 32'h1);
      @(negedge clk);
      chk($sformatf("v%0d_idle", v), {30'h0, done, busy}, 32'h0);
    end

    // Reset while waiting for the index word ack abandons the store
    for (int i = 0; i < 8; i++) ld_val[i] = 16'h0;
    ld_val[0] = 16'h0100;
    ld_val[7] = 16'h0200;
    pulse_ld_regs();
    put_mem(16'h0200, 16'h0020);
    lat = 10; w0 = wr_cnt;
    @(negedge clk);
    mode = 3'd6; reg_sel = 3'd0; byte_op = 1'b0; result = 16'h4321; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("rst_idx_req", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ctl", {3'd0, busy, done, odd_err, mem_req, mem_we, mem_byte, reg_wr_en,
                    reg_rd_addr, reg_wr_addr, mem_addr}, 32'h0);
    chk("rst_data", {mem_wdata, reg_wr_data}, 32'h0);
    chk("rst_pc", {16'h0, regs[7]}, 32'h0200);
    rst_n = 1'b1;
    lat = 0;
    run_store(3'd6, 3'd0, 1'b0, 16'h4321);
    chk("rst_after_done", {31'h0, got_done}, 32'h1);
    chk("rst_after_pc", {16'h0, regs[7]}, 32'h0202);
    chk("rst_after_waddr", {16'h0, last_waddr}, 32'h0120);
    chk("rst_after_wrcnt", wr_cnt - w0, 32'h1);

    // Randomized stores against the behavioural model
    for (int t = 0; t < 200; t++) begin
      logic [2:0]  rm, rrs;
      logic        rb;
      logic [15:0] rres;
      for (int i = 0; i < 8; i++) begin
        ld_val[i] = 16'($urandom);
        if ($urandom_range(0, 3) != 0) ld_val[i][0] = 1'b0;
      end
      ld_val[7][0] = 1'b0;
      pulse_ld_regs();
      lat  = $urandom_range(0, 3);
      rm   = 3'($urandom_range(0, 7));
      rrs  = 3'($urandom_range(0, 7));
      rb   = 1'($urandom_range(0, 1));
      rres = 16'($urandom);
      model(rm, rrs, rb, rres);
      w0 = wr_cnt;
      run_store(rm, rrs, rb, rres);
      for (int i = 0; i < 8; i++)
        chk($sformatf("r%0d_m%0d_reg%0d", t, rm, i), {16'h0, regs[i]}, {16'h0, m_regs[i]});
      chk($sformatf("r%0d_err", t), {31'h0, got_err}, {31'h0, m_err});
      chk($sformatf("r%0d_done", t), {31'h0, got_done}, {31'h0, ~m_err});
      chk($sformatf("r%0d_wrcnt", t), wr_cnt - w0, {31'h0, m_wr});
      if (m_wr) begin
        chk($sformatf("r%0d_waddr", t), {16'h0, last_waddr}, {16'h0, m_addr});
        chk($sformatf("r%0d_wdata", t), {16'h0, last_wdata}, {16'h0, m_data});
        chk($sformatf("r%0d_wbyte", t), {31'h0, last_wbyte}, {31'h0, m_byte});
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
